// File: rtl/uart_transmitter.sv
// uart_transmitter: UART serialiser with a one-byte holding register.
// Frames are 8N1, or 8E1 when UART_TX_PARITY_EN is defined (even parity).
// A byte can be accepted while the previous frame is on the line, so a frame
// in flight plus one pending byte gives back-to-back frames with no idle gap.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-low reset
//   tx_data  - byte to send, taken when tx_valid && tx_ready
//   tx_valid - producer has a byte
//   tx_ready - holding register empty (registered)
//   tx_busy  - frame in progress or byte pending (registered)
//   tx_done  - one-cycle pulse after a stop bit completes (registered)
//   uart_tx  - serial line, idle high (registered)
module uart_transmitter #(
  parameter int unsigned CLK_FREQ_HZ = 20_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  uart_tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(DATA_WIDTH) + 1;

  generate
    if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("uart_transmitter: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  uart_tx_q, uart_tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_last;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      uart_tx_q   <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      uart_tx_q   <= uart_tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Next-state logic; outputs are computed from the next state so the line
  // changes on the same edge the FSM enters a new bit.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    // ready_q mirrors ~hold_full_q, so acceptance and a load never coincide
    if (tx_valid && ready_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          baud_d      = '0;
          state_d     = START;
`ifdef UART_TX_PARITY_EN
          parity_d    = ^hold_q;
`endif
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          done_d = 1'b1;
          baud_d = '0;
          // Pending byte starts immediately for a gap-free next frame
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^hold_q;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Registered output values derived from the next state
  always_comb begin
    uart_tx_d = 1'b1;
    case (state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  uart_tx_d = parity_d;
`endif
      default: uart_tx_d = 1'b1;
    endcase
    ready_d = ~hold_full_d;
    busy_d  = (state_d != IDLE) || hold_full_d;
  end

  assign uart_tx  = uart_tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter that drives the `uart_tx` pin of `computer`. It is the transmitting end of the link whose receive side is `uart_rx`. It accepts bytes from the CPU-side I/O decode through a valid/ready handshake and buffers one byte in a holding register. Each byte is serialised LSB-first as 8N1, or 8E1 when parity is compiled in. The block also serves as the stimulus source in testbenches that exercise `uart_rx` instead of tying it high.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 20_000_000: system clock frequency.
- `BAUD_RATE`, 115_200: line bit rate.
  - `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE`, using integer division (truncated).
  - Elaboration fails (`$error`) if `CLKS_PER_BIT < 2`.
- `DATA_WIDTH`, 8: payload bits per frame (from `arch_defs_pkg`).

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `tx_data`, input, `DATA_WIDTH`: byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`, input, 1: producer has a byte.
- `tx_ready`, output, 1: holding register empty. Equals `~hold_full`, driven straight from a register.
- `tx_busy`, output, 1: `state != IDLE || hold_full`.
- `tx_done`, output, 1: one-cycle pulse when a stop bit completes.
- `uart_tx`, output, 1: serial line, idle high, registered output.

## Operation
- Reset (`reset == 0` at an edge):
  - State goes to IDLE; holding register and shift register are cleared.
  - `uart_tx = 1`, `tx_ready = 1`, `tx_busy = 0`, `tx_done = 0`.
- Acceptance: at an edge with `tx_valid && tx_ready`, `tx_data` is latched into the holding register and `hold_full` is set. `tx_valid` while `tx_ready = 0` is ignored; nothing is dropped silently, because the producer must hold its byte.
- FSM states are IDLE, START, DATA, PARITY (exists only with the macro), STOP.
  - IDLE with `hold_full`: the holding register moves to the shift register, `hold_full` clears, next state is START.
  - START: `uart_tx = 0` for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: sends `shift[0]` for `CLKS_PER_BIT` cycles, then shifts right. After `DATA_WIDTH` bits it goes to PARITY if enabled, otherwise STOP.
  - PARITY: sends the even-parity bit for `CLKS_PER_BIT` cycles, then STOP.
  - STOP: `uart_tx = 1` for `CLKS_PER_BIT` cycles. On the final cycle:
    - `tx_done` pulses.
    - If `hold_full`, the holding byte loads directly and the FSM enters START with zero idle gap.
    - Otherwise the FSM enters IDLE.
- Counters:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits; it counts 0 to `CLKS_PER_BIT-1` and resets on every state change.
  - Bit index counter is `$clog2(DATA_WIDTH)+1` bits.
- Simultaneous events:
  - The holding register can refill while a frame is in flight (one frame plus one pending).
  - A load from holding and a new acceptance never occur on the same edge, because `tx_ready = 0` whenever `hold_full`.
- Reset mid-frame: the line returns high at the reset edge and the pending byte is discarded. The truncated frame on the line is accepted behaviour.

## Timing
- Acceptance edge N with FSM in IDLE:
  - START (`uart_tx` low) is visible from edge N+1.
  - Data bit k occupies cycles N+1+(k+1)·CPB through N+(k+2)·CPB, where CPB = `CLKS_PER_BIT`.
- Frame length is exactly 10·CPB cycles (11·CPB with parity).
- `tx_done` is high for the single cycle following the last stop-bit cycle, coincident with the START of a back-to-back frame if one is pending.
- `tx_ready` returns to 1 the cycle after the holding register is transferred to the shift register.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in and each frame is 8E1.
  - Parity bit = XOR of the data bits, so the total count of ones in data plus parity is even.
- `UART_TX_PARITY_EN` undefined: no PARITY state or logic, and frames are 8N1.

## Test plan
All scenarios use `CLK_FREQ_HZ=40`, `BAUD_RATE=10`, giving CPB = 4.
- Reset values: hold `reset=0` for 3 cycles → `uart_tx=1`, `tx_ready=1`, `tx_busy=0`, `tx_done=0`.
- Single byte: send `8'hA5` → `uart_tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses once, 40 cycles after START begins.
- Back-to-back: send `8'h55`, then `8'hAA` on the next ready cycle.
  - `tx_ready=0` until the first frame begins.
  - Second START begins on the cycle right after the first STOP ends, with no idle high gap.
  - `tx_busy` stays high continuously for 80 cycles.
- Backpressure: hold `tx_valid=1` with `8'h01`, `8'h02`, `8'h03` while `tx_ready=0` → each byte is transmitted exactly once, in order, and none is lost.
- Reset mid-frame: assert reset at data bit 3 of `8'h00` → `uart_tx=1` the next cycle, `tx_busy=0`, the pending byte is discarded, and no `tx_done` pulse occurs.
- Parity, with `UART_TX_PARITY_EN` defined: `8'h07` → parity bit 1; `8'h03` → parity bit 0; frame length 44 cycles.
